// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
// Imported by the picker, the top level and the bench.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int MAX_CHAN = 16;

    // Width of a channel index for n channels. A single channel still needs one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [chan_w(MAX_CHAN)-1:0] chan_idx_t;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer-side and consumer-side handshake bundle of stream_mux_rr.
// master = environment side, slave = the multiplexer.
interface stream_mux_rr_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SELW = $clog2(N);

    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/stream_mux_rr_pick.sv
// Combinational rotate-priority finder: the first requesting channel
// strictly after `last`, wrapping from N-1 back to 0.
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = chan_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] cand;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = SELW'((int'(last) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// The grant is either software-selected or round-robin over requesting channels.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = chan_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] select,
    stream_mux_rr_if.slave  bus
);

    logic            load_en;
    logic            grant;
    logic            transfer;
    logic [SELW-1:0] g;
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic [SELW-1:0] last;

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [SELW-1:0] out_chan_q;

    logic [W-1:0]    chan_data [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign chan_data[k] = bus.in_data[k*W +: W];
    end

    rr_pick #(.N(N)) u_pick (
        .req   (bus.in_valid),
        .last  (last),
        .found (rr_found),
        .idx   (rr_idx)
    );

    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        grant = 1'b0;
        g     = '0;
        if (mode == MODE_RR) begin
            grant = rr_found;
            g     = rr_idx;
        end else if (int'(select) < N && bus.in_valid[select]) begin
            grant = 1'b1;
            g     = select;
        end
    end

    assign transfer = load_en && grant;

    // Reset gates ready directly so no producer sees a handshake while the register is cleared.
    assign bus.in_ready = (transfer && rst_n) ? (N'(1) << g) : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last        <= SELW'(N - 1);
        end else begin
            if (load_en) begin
                out_valid_q <= grant;
                if (grant) begin
                    out_data_q <= chan_data[g];
                    out_chan_q <= g;
                end
            end
            if (transfer && mode == MODE_RR) begin
                last <= g;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and randomized checks of stream_mux_rr against a beat-level
// reference model of the grant rules and the single output register.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       mode    = 1'b0;
    logic [1:0] select  = 2'd0;
    logic       mode3   = 1'b0;
    logic [1:0] select3 = 2'd0;

    stream_mux_rr_if #(.N(N), .W(W)) bus  ();
    stream_mux_rr_if #(.N(3), .W(W)) bus3 ();

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .select (select),
        .bus    (bus.slave)
    );

    stream_mux_rr #(.N(3), .W(W)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode3),
        .select (select3),
        .bus    (bus3.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: contents of the output register and the round-robin pointer.
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_chan;
    logic [1:0] m_last;
    logic       e_found;
    logic [1:0] e_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_chan  = 2'd0;
        m_last  = 2'(N - 1);
    endtask

    task automatic model_grant();
        int c;
        e_found = 1'b0;
        e_g     = 2'd0;
        if (mode == MODE_SEL) begin
            if (bus.in_valid[select]) begin
                e_found = 1'b1;
                e_g     = select;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (int'(m_last) + k) % N;
                if (!e_found && bus.in_valid[c]) begin
                    e_found = 1'b1;
                    e_g     = 2'(c);
                end
            end
        end
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic cycle();
        logic       load;
        logic [3:0] exp_rdy;
        #1;
        model_grant();
        load    = !m_valid || bus.out_ready;
        exp_rdy = (load && e_found) ? 4'(1 << e_g) : 4'b0000;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (load) begin
            if (e_found) begin
                m_valid = 1'b1;
                m_data  = 8'(bus.in_data >> (8 * int'(e_g)));
                m_chan  = e_g;
                if (mode == MODE_RR) m_last = e_g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data",  32'(bus.out_data),  32'(m_data));
        chk("out_chan",  32'(bus.out_chan),  32'(m_chan));
    endtask

    initial begin
        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus3.in_valid  = '0;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b0;
        model_reset();

        // Reset state, with requests present to show ready is held low.
        mode         = MODE_RR;
        bus.in_valid = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data",  32'(bus.out_data),  32'h0);
        chk("rst_out_chan",  32'(bus.out_chan),  32'h0);
        rst_n = 1'b1;

        // Explicit select of channel 2.
        mode          = MODE_SEL;
        select        = 2'd2;
        bus.in_valid  = 4'b0100;
        bus.in_data   = 32'h00A5_0000;
        bus.out_ready = 1'b1;
        cycle();
        chk("sel_data", 32'(bus.out_data), 32'hA5);
        chk("sel_chan", 32'(bus.out_chan), 32'd2);

        // Round-robin with all channels valid: 0,1,2,3,0,1,2,3.
        mode         = MODE_RR;
        bus.in_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = $urandom;
            cycle();
            chk("rr_seq", 32'(bus.out_chan), 32'(i % N));
        end

        // Wrap-around between channels 3 and 0.
        bus.in_valid = 4'b1001;
        cycle();
        chk("wrap_0", 32'(bus.out_chan), 32'd0);
        cycle();
        chk("wrap_3", 32'(bus.out_chan), 32'd3);

        // Backpressure for three cycles, then drain and fill on the same edge.
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b0;
        repeat (3) begin
            bus.in_data = $urandom;
            cycle();
            chk("bp_hold_chan", 32'(bus.out_chan), 32'd3);
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_release_chan", 32'(bus.out_chan), 32'd0);

        // Reset mid-stream with a beat held in the output register.
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'h0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_chan", 32'(bus.out_chan), 32'd0);

        // Randomized mode, select, valid, data and backpressure.
        repeat (300) begin
            mode          = 1'($urandom);
            select        = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom % 4) != 0;
            cycle();
        end

        // Three-channel instance: select past the last channel never grants.
        mode3          = MODE_SEL;
        select3        = 2'd2;
        bus3.in_valid  = 3'b111;
        bus3.in_data   = 24'h3C_0000;
        bus3.out_ready = 1'b1;
        #1;
        chk("n3_ready_sel2", 32'(bus3.in_ready), 32'b100);
        @(posedge clk);
        #1;
        chk("n3_valid_sel2", 32'(bus3.out_valid), 32'h1);
        chk("n3_data_sel2",  32'(bus3.out_data),  32'h3C);
        select3 = 2'd3;
        #1;
        chk("n3_ready_sel3", 32'(bus3.in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("n3_valid_sel3", 32'(bus3.out_valid), 32'h0);
        chk("n3_chan_hold",  32'(bus3.out_chan),  32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshaking and a registered output stage. It succeeds the combinational 4:1 select mux. Channel choice is either software-selected (explicit `select`) or fair round-robin across requesting channels. It sits between N producer streams and a single consumer, e.g. merging per-lane results onto one bus.

## Interface
Parameters:
- `N`, default 4: number of input channels, 2..16.
- `W`, default 8: data width per channel, ≥1.
- `SELW`, default `$clog2(N)`: derived local parameter for select/channel width; not overridable.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = explicit select, 1 = round-robin.
- `select`  in  SELW  channel index used when `mode`=0.
- `in_valid`  in  N  per-channel valid.
- `in_data`  in  N*W  channel k occupies bits [k*W +: W].
- `in_ready`  out  N  per-channel ready; at most one bit high.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  registered data.
- `out_chan`  out  SELW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accepts beat.

## Operation
- Output stage is one register (`out_valid`, `out_data`, `out_chan`).
- `load_en` = !out_valid | out_ready. Computed each cycle.
- Grant `g` is combinational. Only a channel with `in_valid[g]`=1 is granted.
- Grant in mode 0: `g` = `select`, if `select` < N and `in_valid[select]`; otherwise no grant. `select` ≥ N never grants.
- Grant in mode 1: search from `last`+1 upward, wrapping N-1→0. The first channel with valid set is granted.
- `in_ready[g]` = load_en & grant. All other `in_ready` bits are 0.
- Transfer in = `in_valid[g]` & `in_ready[g]`. On transfer, the register loads `in_data[g]`, `g`, and sets `out_valid`=1.
- If `load_en`=1 and no grant, `out_valid` clears to 0. `out_data`/`out_chan` hold their last values.
- `last` updates to `g` only on a transfer in mode 1. Mode 0 transfers leave `last` unchanged.
- `mode`/`select` may change on any cycle. The change affects the grant in the same cycle; no beat is lost or duplicated.
- `in_ready` may depend on `in_valid`. No output depends combinationally on `out_ready` except `in_ready`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `last`=N-1, so the first RR search starts at channel 0. `in_ready` is 0 while `rst_n`=0.
- Latency is 1 cycle: a beat accepted at edge t is visible on `out_*` after edge t.
- Throughput is 1 beat/cycle with `out_ready` held high, including back-to-back beats from the same channel.
- Backpressure: when `out_valid`=1 and `out_ready`=0, all `in_ready`=0 and `out_*` is stable.
- Simultaneous drain+fill: when `out_ready`=1 and a grant exists, the old beat leaves and the new beat loads on the same edge.
- Reset mid-operation: the in-flight beat is discarded and `last` returns to N-1 immediately (asynchronously).
- RR fairness: with all N channels continuously valid, each channel is granted exactly once per N transfers.

## Structure
- Package `stream_mux_pkg` holds:
  - mode constants `MODE_SEL`=1'b0 and `MODE_RR`=1'b1;
  - a `chan_idx_t` width helper.
- Sub-module `rr_pick`: combinational N-way rotate-priority finder. Inputs are the request vector and the `last` pointer; outputs are `found` and index. Mode 0 bypasses it.
- Top level contains the grant mux, output register, and `last` register.

## Test plan
- Reset, then mode 0, `select`=2, `in_valid`=4'b0100, `in_data[2]`=8'hA5, `out_ready`=1 -> `in_ready`=4'b0100; next cycle `out_valid`=1, `out_data`=8'hA5, `out_chan`=2.
- Mode 1, all four channels valid for 8 cycles, `out_ready`=1 -> `out_chan` sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
- Mode 1, `in_valid`=4'b1001 after a grant to 3 -> next grant 0, then 3 (wrap-around).
- Hold `out_ready`=0 for 3 cycles with a beat present -> `in_ready`=0, `out_data` unchanged. Then release -> new beat loads on the same edge the old beat drains.
- Mode 0, N=3, `select`=3 with all valid -> no `in_ready`; `out_valid` drops to 0 after the current beat drains.
- Assert `rst_n`=0 mid-stream with `out_valid`=1 -> `out_valid`=0 immediately. After release in mode 1, the first grant is channel 0.
